// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiply skip RUN.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [4:0]        rd_in,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rd,
  output logic [XLEN-1:0]   data,
  output logic              reg_write
);

  localparam int unsigned PW = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  XONES    = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic              mzero_q, mzero_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              reg_write_q, reg_write_d;

  // Operand decode at acceptance: signedness, magnitudes, special cases
  logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c;
  logic            div0_c, ovf_c, mzero_c, early_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;

  always_comb begin
    a_signed_c = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed_c = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg_c    = a_signed_c && rs1_data[XLEN-1];
    b_neg_c    = b_signed_c && rs2_data[XLEN-1];
    a_mag_c    = a_neg_c ? -rs1_data : rs1_data;
    b_mag_c    = b_neg_c ? -rs2_data : rs2_data;
    div0_c     = funct3[2] && (rs2_data == '0);
    ovf_c      = funct3[2] && !funct3[0] && (rs1_data == XMIN) && (rs2_data == XONES);
    mzero_c    = !funct3[2] && ((rs1_data == '0) || (rs2_data == '0));
    early_c    = div0_c || ovf_c || mzero_c;
  end

  // Per-iteration datapath: hi/lo hold product halves or remainder/quotient
  logic [XLEN:0]   mul_sum_c;
  logic [XLEN:0]   div_shift_c;
  logic            div_ge_c;
  logic [XLEN-1:0] div_sub_c;

  always_comb begin
    mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
    div_shift_c = {hi_q, lo_q[XLEN-1]};
    div_ge_c    = div_shift_c >= {1'b0, b_mag_q};
    div_sub_c   = div_shift_c[XLEN-1:0] - b_mag_q;
  end

  // Final sign fix-up and special-case override
  logic [PW-1:0]   prod_c, prod_s_c;
  logic [XLEN-1:0] quot_s_c, rem_s_c, a_orig_c, result_c;

  always_comb begin
    prod_c   = {hi_q, lo_q};
    prod_s_c = (a_neg_q ^ b_neg_q) ? -prod_c : prod_c;
    quot_s_c = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
    rem_s_c  = a_neg_q ? -hi_q : hi_q;
    a_orig_c = a_neg_q ? -a_mag_q : a_mag_q;
    case (op_q)
      3'd0:                result_c = prod_s_c[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    result_c = prod_s_c[PW-1:XLEN];
      3'd4, 3'd5:          result_c = quot_s_c;
      default:             result_c = rem_s_c;
    endcase
    if (mzero_q) begin
      result_c = '0;
    end else if (div0_q) begin
      result_c = op_q[1] ? a_orig_c : XONES;
    end else if (ovf_q) begin
      result_c = op_q[1] ? '0 : XMIN;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_lat_d    = rd_lat_q;
    a_mag_d     = a_mag_q;
    b_mag_d     = b_mag_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    mzero_d     = mzero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = funct3;
          rd_lat_d = rd_in;
          a_mag_d  = a_mag_c;
          b_mag_d  = b_mag_c;
          a_neg_d  = a_neg_c;
          b_neg_d  = b_neg_c;
          div0_d   = div0_c;
          ovf_d    = ovf_c;
          mzero_d  = mzero_c;
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = funct3[2] ? a_mag_c : b_mag_c;
`ifdef MULDIV_EARLY_OUT_EN
          state_d  = early_c ? DONE : RUN;
`else
          state_d  = RUN;
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[2]) begin
          hi_d = div_ge_c ? div_sub_c : div_shift_c[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge_c};
        end else begin
          hi_d = mul_sum_c[XLEN:1];
          lo_d = {mul_sum_c[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d     = IDLE;
        done_d      = 1'b1;
        reg_write_d = (rd_lat_q != 5'd0);
        rd_d        = rd_lat_q;
        data_d      = result_c;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      rd_lat_q    <= '0;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mzero_q     <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_lat_q    <= rd_lat_d;
      a_mag_q     <= a_mag_d;
      b_mag_q     <= b_mag_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      mzero_q     <= mzero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd        = rd_q;
  assign data      = data_q;
  assign reg_write = reg_write_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (honours MULDIV_EARLY_OUT_EN for special-case latency).
module tb_muldiv_unit;

  localparam int LAT_FULL = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_SPEC = 2;
`else
  localparam int LAT_SPEC = 34;
`endif

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [4:0]  rd;
  logic [31:0] data;
  logic        reg_write;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .rd        (rd),
    .data      (data),
    .reg_write (reg_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for done, check result, latency and busy span
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                       input int exp_lat, input bit glitch);
    int n;
    int nbusy;
    bit seen;
    @(negedge clock);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = r; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n = 0; nbusy = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clock);
      n++;
      if (glitch && n == 5) begin
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd9;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busycnt"}, 32'(nbusy), 32'(exp_lat - 1));
    chk({tag, "_data"}, data, exp);
    chk({tag, "_rd"}, 32'(rd), 32'(r));
    chk({tag, "_wr"}, 32'(reg_write), 32'(r != 5'd0));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clock);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_wr_drop"}, 32'(reg_write), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; funct3 = 3'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr", 32'(reg_write), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_data", data, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    do_op("mul",    3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, LAT_FULL, 1'b0);
    do_op("mulh",   3'd1, 32'h80000000,   32'hFFFFFFFF, 5'd1,  32'h00000000, LAT_FULL, 1'b0);
    do_op("mulhsu", 3'd2, 32'h80000000,   32'hFFFFFFFF, 5'd2,  32'h80000000, LAT_FULL, 1'b0);
    do_op("mulhu",  3'd3, 32'h80000000,   32'hFFFFFFFF, 5'd3,  32'h7FFFFFFF, LAT_FULL, 1'b0);
    do_op("div",    3'd4, 32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFD, LAT_FULL, 1'b0);
    do_op("rem",    3'd6, 32'hFFFFFFF9,   32'd2,        5'd11, 32'hFFFFFFFF, LAT_FULL, 1'b0);
    do_op("divu",   3'd5, 32'hFFFFFFFF,   32'h10,       5'd12, 32'h0FFFFFFF, LAT_FULL, 1'b0);
    do_op("remu",   3'd7, 32'd100,        32'd7,        5'd13, 32'd2,        LAT_FULL, 1'b0);
    do_op("mul_big",3'd0, 32'h12345678,   32'h00010000, 5'd14, 32'h56780000, LAT_FULL, 1'b0);
    do_op("divu_z", 3'd5, 32'd55,         32'd0,        5'd20, 32'hFFFFFFFF, LAT_SPEC, 1'b0);
    do_op("rem_z",  3'd6, 32'd13,         32'd0,        5'd21, 32'd13,       LAT_SPEC, 1'b0);
    do_op("remn_z", 3'd6, 32'hFFFFFFF3,   32'd0,        5'd22, 32'hFFFFFFF3, LAT_SPEC, 1'b0);
    do_op("div_ov", 3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd23, 32'h80000000, LAT_SPEC, 1'b0);
    do_op("rem_ov", 3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd24, 32'h00000000, LAT_SPEC, 1'b0);
    do_op("mul_z",  3'd1, 32'd0,          32'hFFFFFFFF, 5'd25, 32'h00000000, LAT_SPEC, 1'b0);
    do_op("glitch", 3'd0, 32'd6,          32'd7,        5'd6,  32'd42,       LAT_FULL, 1'b1);
    do_op("rd0",    3'd0, 32'd4,          32'd5,        5'd0,  32'd20,       LAT_FULL, 1'b0);

    // Abort mid-RUN with reset; outputs must drop at once and stay low
    @(negedge clock);
    funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (11) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wr", 32'(reg_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_hold_busy", 32'(busy), 32'd0);
      chk("abort_hold_done", 32'(done), 32'd0);
      chk("abort_hold_wr", 32'(reg_write), 32'd0);
    end
    reset_n = 1'b1;
    do_op("post_rst", 3'd0, 32'd9, 32'd9, 5'd7, 32'd81, LAT_FULL, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
